mul_share_sched: RTL

- Time-shares one external pipelined unsigned multiplier (10x18 -> 28 bits, fixed latency) among N_REQ requesters in the bicubic interpolation datapath, e.g. the per-tap weight x pixel products.
- Issues at most one product per clock, granted by round-robin arbitration.
- Carries a requester tag alongside each operation and returns each product to its originator in issue order.

---
 rtl/mul_share_sched.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mul_share_sched.sv
// mul_share_sched: shares one external pipelined multiplier among N_REQ
// requesters. Requesters are granted round-robin, at most one per clock.
// Each issued product carries the requester's tag through a shift register
// that matches the multiplier latency. The product is returned, one-hot
// addressed, to the requester that issued it.
module mul_share_sched #(
   parameter int N_REQ   = 4,
   parameter int A_W     = 10,
   parameter int B_W     = 18,
   parameter int P_W     = 28,
   parameter int MUL_LAT = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*A_W-1:0]   req_a,
   input  logic [N_REQ*B_W-1:0]   req_b,
   output logic [N_REQ-1:0]       req_ready,
   output logic [A_W-1:0]         mul_a,
   output logic [B_W-1:0]         mul_b,
   input  logic [P_W-1:0]         mul_result,
   output logic [N_REQ-1:0]       rsp_valid,
   output logic [P_W-1:0]         rsp_data,
   output logic                   idle
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PTR_W-1:0] ptr;
   logic [N_REQ-1:0] grant;
   logic [PTR_W-1:0] gnt_idx;
   logic             hs;
   logic [A_W-1:0]   gnt_a;
   logic [B_W-1:0]   gnt_b;

   logic             vld_p0;
   logic [PTR_W-1:0] tag_p0;

   // Stage s of the tag pipe lines up with multiplier stage s. Stage
   // MUL_LAT lines up with mul_result.
   logic             vld_pipe [1:MUL_LAT];
   logic [PTR_W-1:0] tag_pipe [1:MUL_LAT];
   logic             pipe_busy;

   function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Round-robin scan starting at ptr. The first valid requester wins.
   // A grant only goes to a valid requester, so a grant is always a handshake.
   always_comb begin
      int idx;
      grant   = '0;
      gnt_idx = '0;
      hs      = 1'b0;
      idx     = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(ptr) + k) % N_REQ;
         if (en && !hs && req_valid[idx]) begin
            grant[idx] = 1'b1;
            gnt_idx    = PTR_W'(idx);
            hs         = 1'b1;
         end
      end
   end

   assign req_ready = grant;
   assign gnt_a     = req_a[int'(gnt_idx)*A_W +: A_W];
   assign gnt_b     = req_b[int'(gnt_idx)*B_W +: B_W];

   // Pointer moves just past the requester that was served.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr <= '0;
      else if (hs)
         ptr <= (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
   end

   // ---- stage p0: operand issue register feeding the multiplier ----
   // The operands hold when nothing is issued, so the multiplier inputs do not toggle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0 <= 1'b0;
         tag_p0 <= '0;
         mul_a  <= '0;
         mul_b  <= '0;
      end else begin
         vld_p0 <= hs;
         if (hs) begin
            tag_p0 <= gnt_idx;
            mul_a  <= gnt_a;
            mul_b  <= gnt_b;
         end
      end
   end

   // ---- tag pipe: MUL_LAT stages, advances every clock, never stalls ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 1; s <= MUL_LAT; s++) begin
            vld_pipe[s] <= 1'b0;
            tag_pipe[s] <= '0;
         end
      end else begin
         vld_pipe[1] <= vld_p0;
         tag_pipe[1] <= tag_p0;
         for (int s = 2; s <= MUL_LAT; s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            tag_pipe[s] <= tag_pipe[s-1];
         end
      end
   end

   // ---- response stage: capture the product and route it to its owner ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= '0;
         rsp_data  <= '0;
      end else if (vld_pipe[MUL_LAT]) begin
         rsp_valid <= onehot(tag_pipe[MUL_LAT]);
         rsp_data  <= mul_result;
      end else begin
         rsp_valid <= '0;
      end
   end

   // Any op still in the tag pipe keeps the block busy.
   always_comb begin
      pipe_busy = 1'b0;
      for (int s = 1; s <= MUL_LAT; s++)
         pipe_busy = pipe_busy | vld_pipe[s];
   end

   assign idle = ~(vld_p0 | pipe_busy | (|rsp_valid));

endmodule
